// File: rtl/wc_pkg.sv
// Shared definitions for the WC chip host link: word width, sync marker and FSM states.
package wc_pkg;

  localparam int WORD_W = 10;
  localparam logic [WORD_W-1:0] SYNC_WORD = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT,
    CAPTURE,
    DRAIN
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/wc_word_buf.sv
// Depth x WORD_W register array: sequential writes through an internal pointer,
// random-access combinational read through an external index.
module wc_word_buf
  import wc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;

  // Pointer wraps after the last entry so every tile starts at entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
    end else if (wr_en) begin
      wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[IDX_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/wc_host_link.sv
// Host-side link to the WC chip: buffers a tile, streams it with a sync word,
// waits the chip latency, captures the results and drains them downstream.
module wc_host_link
  import wc_pkg::*;
#(
  parameter int IN_WORDS  = 16,
  parameter int OUT_WORDS = 4,
  parameter int LATENCY   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] D,
  input  logic [WORD_W-1:0] Z,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy
);

  localparam int MAX_CNT   = max3(IN_WORDS, LATENCY, OUT_WORDS);
  localparam int CNT_W     = $clog2(MAX_CNT) + 1;
  localparam int IN_IDX_W  = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
  localparam int OUT_IDX_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic              tile_wr;
  logic [IN_IDX_W-1:0]  tile_rd_idx;
  logic [WORD_W-1:0] tile_rd_data;
  logic              res_wr;
  logic [OUT_IDX_W-1:0] res_rd_idx;
  logic [WORD_W-1:0] res_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // One shared counter: beats in LOAD, D slot in SEND, delay in WAIT,
  // capture slot in CAPTURE and drain index in DRAIN; cleared on every exit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE, LOAD: begin
        if (s_valid) begin
          if (cnt_reg == CNT_W'(IN_WORDS - 1)) begin
            state_next = SEND;
            cnt_next   = '0;
          end else begin
            state_next = LOAD;
            cnt_next   = cnt_reg + 1'b1;
          end
        end
      end
      SEND: begin
        if (cnt_reg == CNT_W'(IN_WORDS)) begin
          state_next = (LATENCY == 1) ? CAPTURE : WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT: begin
        if (cnt_reg == CNT_W'(LATENCY - 2)) begin
          state_next = CAPTURE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      CAPTURE: begin
        if (cnt_reg == CNT_W'(OUT_WORDS - 1)) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (m_ready) begin
          if (cnt_reg == CNT_W'(OUT_WORDS - 1)) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign s_ready = !rst && ((state_reg == IDLE) || (state_reg == LOAD));
  assign tile_wr = s_valid && s_ready;
  // Slot 0 of SEND carries the sync word, so entry n goes out in slot n+1.
  assign tile_rd_idx = IN_IDX_W'(cnt_reg - 1'b1);
  assign D = (state_reg != SEND)  ? '0 :
             (cnt_reg == '0)      ? SYNC_WORD : tile_rd_data;

  assign res_wr     = (state_reg == CAPTURE);
  assign res_rd_idx = OUT_IDX_W'(cnt_reg);
  assign m_valid    = (state_reg == DRAIN);
  assign m_data     = m_valid ? res_rd_data : '0;
  assign busy       = (state_reg != IDLE);

  wc_word_buf #(
    .DEPTH (IN_WORDS)
  ) u_tile_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tile_wr),
    .wr_data (s_data),
    .rd_idx  (tile_rd_idx),
    .rd_data (tile_rd_data)
  );

  wc_word_buf #(
    .DEPTH (OUT_WORDS)
  ) u_res_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (res_wr),
    .wr_data (Z),
    .rd_idx  (res_rd_idx),
    .rd_data (res_rd_data)
  );

endmodule

// File: tb/tb_wc_host_link.sv
// Scoreboard bench for wc_host_link: instance 0 at LATENCY=8, instance 1 at LATENCY=1,
// each paired with a behavioural WC chip model that answers on Z.
module tb_wc_host_link;

  localparam int NIN  = 16;
  localparam int NOUT = 4;
  localparam logic [9:0] SYNC = 10'h3FF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] s_data  [2];
  logic       s_valid [2];
  logic       m_ready [2];
  wire        s_ready [2];
  wire  [9:0] d_bus   [2];
  wire  [9:0] z       [2];
  wire  [9:0] m_data  [2];
  wire        m_valid [2];
  wire        busy    [2];

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;

  logic [9:0] d_q    [$];
  logic [9:0] r_q    [$];
  int         base_q [$];

  bit         active   [2];
  int         k        [2];
  int         cur_base [2];
  int         beats    [2];
  int         beat16   [2];
  bit         rst_seen [2];
  bit         hold_v   [2];
  logic [9:0] hold_d   [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 8 : 1;

    wc_host_link #(
      .IN_WORDS  (NIN),
      .OUT_WORDS (NOUT),
      .LATENCY   (LAT)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_data  (s_data[gi]),
      .s_valid (s_valid[gi]),
      .s_ready (s_ready[gi]),
      .D       (d_bus[gi]),
      .Z       (z[gi]),
      .m_data  (m_data[gi]),
      .m_valid (m_valid[gi]),
      .m_ready (m_ready[gi]),
      .busy    (busy[gi])
    );

    // Chip model: result j is valid only during the cycle LAT+j after the last tile word.
    assign z[gi] = (active[gi] && k[gi] >= NIN + LAT && k[gi] < NIN + LAT + NOUT)
                   ? 10'(cur_base[gi] + k[gi] - NIN - LAT + 1) : 10'h2AA;
  end

  function automatic int lat_of(input int u);
    return (u == 0) ? 8 : 1;
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: all comparisons happen here on the falling edge.
  always @(negedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        check(s_ready[u] == 1'b0, "s_ready_in_reset", int'(s_ready[u]), 0);
        active[u]   = 1'b0;
        beats[u]    = 0;
        rst_seen[u] = 1'b1;
        hold_v[u]   = 1'b0;
      end else begin
        if (rst_seen[u]) begin
          check(busy[u] == 1'b0,    "post_rst_busy",    int'(busy[u]),    0);
          check(d_bus[u] == 10'h0,  "post_rst_D",       int'(d_bus[u]),   0);
          check(m_valid[u] == 1'b0, "post_rst_m_valid", int'(m_valid[u]), 0);
          check(m_data[u] == 10'h0, "post_rst_m_data",  int'(m_data[u]),  0);
          check(s_ready[u] == 1'b1, "post_rst_s_ready", int'(s_ready[u]), 1);
          rst_seen[u] = 1'b0;
        end

        if (s_valid[u] && s_ready[u]) begin
          beats[u]++;
          if (beats[u] == NIN) begin
            beat16[u] = cyc;
            beats[u]  = 0;
          end
        end

        if (!active[u] && busy[u] && d_bus[u] == SYNC) begin
          active[u] = 1'b1;
          k[u]      = 0;
          check(cyc == beat16[u] + 1, "send_start_cycle", cyc, beat16[u] + 1);
          if (base_q.size() == 0) begin
            check(1'b0, "unexpected_tile", 0, 1);
            cur_base[u] = 0;
          end else begin
            cur_base[u] = base_q.pop_front();
          end
        end else if (active[u]) begin
          k[u]++;
          if (k[u] >= NIN + lat_of(u) + NOUT) active[u] = 1'b0;
        end

        if (active[u] && k[u] <= NIN) begin
          if (d_q.size() == 0) begin
            check(1'b0, "unexpected_D", int'(d_bus[u]), 0);
          end else begin
            logic [9:0] exp_d;
            exp_d = d_q.pop_front();
            check(d_bus[u] == exp_d, "D_word", int'(d_bus[u]), int'(exp_d));
          end
        end else if (!busy[u]) begin
          check(d_bus[u] == 10'h0, "D_idle", int'(d_bus[u]), 0);
        end

        if (active[u] || m_valid[u]) begin
          check(s_ready[u] == 1'b0, "s_ready_busy", int'(s_ready[u]), 0);
        end

        if (hold_v[u] && m_valid[u]) begin
          check(m_data[u] == hold_d[u], "m_data_hold", int'(m_data[u]), int'(hold_d[u]));
        end else if (hold_v[u]) begin
          check(1'b0, "m_valid_dropped", 0, 1);
        end
        hold_v[u] = m_valid[u] && !m_ready[u];
        hold_d[u] = m_data[u];

        if (m_valid[u] && m_ready[u]) begin
          if (r_q.size() == 0) begin
            check(1'b0, "unexpected_result", int'(m_data[u]), 0);
          end else begin
            logic [9:0] exp_r;
            exp_r = r_q.pop_front();
            $display("result inst=%0d data=%0d expected=%0d cycle=%0d",
                     u, m_data[u], exp_r, cyc);
            check(m_data[u] == exp_r, "m_data", int'(m_data[u]), int'(exp_r));
          end
        end
      end
    end
  end

  task automatic send_tile(input int u, input logic [9:0] w [NIN], input int base,
                           input bit gaps, input bit expect_res);
    bit acc;
    int guard;
    d_q.push_back(SYNC);
    for (int i = 0; i < NIN; i++) d_q.push_back(w[i]);
    base_q.push_back(base);
    if (expect_res) begin
      for (int j = 1; j <= NOUT; j++) r_q.push_back(10'(base + j));
    end
    for (int i = 0; i < NIN; i++) begin
      s_valid[u] = 1'b1;
      s_data[u]  = w[i];
      guard = 0;
      do begin
        @(negedge clk);
        acc = s_ready[u];
        @(posedge clk);
        #1;
        guard++;
        if (guard > 300) begin
          $display("FAIL tile_accept_timeout: inst %0d word %0d not accepted", u, i);
          $fatal(1);
        end
      end while (!acc);
      if (gaps) begin
        s_valid[u] = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    s_valid[u] = 1'b0;
    $display("tile inst=%0d base=%0d gaps=%0d accepted cycle=%0d", u, base, gaps, cyc);
  endtask

  task automatic wait_idle(input int u);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #2;
      guard++;
    end while ((busy[u] || active[u] || r_q.size() != 0) && guard < 400);
    check(guard < 400, "idle_timeout", guard, 400);
  endtask

  initial begin
    logic [9:0] w [NIN];
    int guard;
    for (int u = 0; u < 2; u++) begin
      s_valid[u] = 1'b0;
      s_data[u]  = '0;
      m_ready[u] = 1'b1;
      active[u]  = 1'b0;
      k[u]       = 0;
      cur_base[u] = 0;
      beats[u]   = 0;
      beat16[u]  = -10;
      rst_seen[u] = 1'b0;
      hold_v[u]  = 1'b0;
      hold_d[u]  = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single tile 1..16, results 101..104.
    for (int i = 0; i < NIN; i++) w[i] = 10'(i + 1);
    send_tile(0, w, 100, 1'b0, 1'b1);
    wait_idle(0);

    // Upstream gaps.
    for (int i = 0; i < NIN; i++) w[i] = 10'(17 + i);
    send_tile(0, w, 200, 1'b1, 1'b1);
    wait_idle(0);

    // Backpressure: stall 5 cycles after the first result handshake.
    for (int i = 0; i < NIN; i++) w[i] = 10'(500 - 3 * i);
    send_tile(0, w, 300, 1'b0, 1'b1);
    guard = 0;
    do begin
      @(posedge clk);
      #2;
      guard++;
    end while (!m_valid[0] && guard < 200);
    check(guard < 200, "drain_timeout", guard, 200);
    @(posedge clk);
    #1 m_ready[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 m_ready[0] = 1'b1;
    wait_idle(0);

    // Reset in the third WAIT cycle: no capture, no results.
    for (int i = 0; i < NIN; i++) w[i] = 10'(40 + i);
    send_tile(0, w, 400, 1'b0, 1'b0);
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (!(active[0] && k[0] == NIN + 2) && guard < 100);
    check(guard < 100, "wait_reach_timeout", guard, 100);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    for (int i = 0; i < NIN; i++) w[i] = 10'(60 + 2 * i);
    send_tile(0, w, 500, 1'b0, 1'b1);
    wait_idle(0);

    // Two tiles back to back.
    for (int i = 0; i < NIN; i++) w[i] = 10'(900 + i);
    send_tile(0, w, 600, 1'b0, 1'b1);
    for (int i = 0; i < NIN; i++) w[i] = 10'(123 * i + 7);
    send_tile(0, w, 700, 1'b0, 1'b1);
    wait_idle(0);

    // LATENCY=1 with 3FF as data, including the first word.
    for (int i = 0; i < NIN; i++) w[i] = 10'(i * 5);
    w[0]  = SYNC;
    w[5]  = SYNC;
    w[15] = SYNC;
    send_tile(1, w, 800, 1'b0, 1'b1);
    wait_idle(1);

    repeat (5) @(posedge clk);
    #1;
    check(d_q.size() == 0,    "d_queue_empty",    d_q.size(),    0);
    check(r_q.size() == 0,    "r_queue_empty",    r_q.size(),    0);
    check(base_q.size() == 0, "base_queue_empty", base_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
